// File: rtl/dmem_access_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_access_arbiter
//
// Shares the byte-addressed, big-endian data memory between two requesters
// (port 0 = CPU MEM stage, port 1 = debug/loader). It sequences every access
// through IDLE -> SETUP -> STROBE -> DONE. Address and write data are stable
// for one cycle before the strobe. Exactly one single-cycle mem_rd or mem_wr
// pulse is issued in STROBE. Misaligned or out-of-range word accesses are
// rejected without any strobe.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration on simultaneous
//                                requests (the port not granted last wins).
//                   undefined -> fixed priority, port 0 always wins ties.
//                                A steady stream of port 0 requests can
//                                starve port 1.
//
// Ports:
//   CLK, Reset               rising-edge clock, synchronous active-high reset
//   req0/we0/addr0/wdata0    port 0 request (hold until ack0), 1=write
//   req1/we1/addr1/wdata1    port 1 request (hold until ack1), 1=write
//   ack0, ack1               one-cycle completion pulse
//   err0, err1               valid with ack: access rejected
//   rdata                    data of last completed read, held until next read
//   mem_rd, mem_wr           memory read / write strobes
//   mem_addr, mem_wdata      memory address / write data
//   mem_rdata                memory read data (valid while mem_rd=1)
//   busy                     access in progress (FSM not in IDLE)
// -----------------------------------------------------------------------------
module dmem_access_arbiter #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  logic   gnt;      // port owning the current access
  logic   lat_we;   // latched direction of the current access
  logic   lat_err;  // current access was rejected
  logic   pick;     // arbitration result while in IDLE

  // mem_addr / mem_wdata double as the latched request registers; they only
  // change when a new request is accepted, so memory inputs never glitch.
  logic [ADDR_W:0] addr_end;
  logic            bad;

  // One extra bit so that an address near the top of the space cannot wrap
  // around into the legal range.
  assign addr_end = {1'b0, mem_addr} + (ADDR_W+1)'(3);
  assign bad      = (mem_addr[1:0] != 2'b00) ||
                    (addr_end >= (ADDR_W+1)'(MEM_BYTES));

`ifdef DMEM_ARB_RR_EN
  logic last_gnt;  // port granted most recently (error grants included)
  assign pick = (req0 && req1) ? ~last_gnt : req1;
`else
  assign pick = ~req0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
`ifdef DMEM_ARB_RR_EN
      last_gnt  <= 1'b1;  // port 0 wins the first tie after reset
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= SETUP;
            gnt       <= pick;
            lat_we    <= pick ? we1    : we0;
            mem_addr  <= pick ? addr1  : addr0;
            mem_wdata <= pick ? wdata1 : wdata0;
`ifdef DMEM_ARB_RR_EN
            last_gnt  <= pick;
`endif
          end
        end
        // ---- SETUP: address/data settle, legality decided ----
        SETUP: begin
          lat_err <= bad;
          mem_rd  <= !bad && !lat_we;
          mem_wr  <= !bad &&  lat_we;
          // Rejected accesses still pass through STROBE (strobes held low)
          // so every grant has the same latency and spacing.
          state   <= STROBE;
        end
        // ---- STROBE: single strobe cycle, read data captured ----
        STROBE: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (mem_rd) begin
            rdata <= mem_rdata;
          end
          ack0  <= ~gnt;
          ack1  <=  gnt;
          err0  <= ~gnt & lat_err;
          err1  <=  gnt & lat_err;
          state <= DONE;
        end
        // ---- DONE: ack pulse visible for this cycle only ----
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for dmem_access_arbiter: directed vector table, hand-written
// multi-cycle sequences (continuous contention, reset mid-access) and
// randomized transactions checked against a transaction-level model with a
// shadow copy of the memory.
// -----------------------------------------------------------------------------
module tb_dmem_access_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  dmem_access_arbiter #(.MEM_BYTES(64), .ADDR_W(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory device (what the DUT talks to) ----------------
  logic [7:0] dev_mem [64];

  always @(posedge CLK) begin
    if (mem_wr) begin
      for (int k = 0; k < 4; k++) begin
        dev_mem[(int'(mem_addr[5:0]) + k) & 63] <= mem_wdata[31-8*k -: 8];
      end
    end
  end

  function automatic logic [31:0] dev_word(input logic [5:0] a);
    int i;
    i = int'(a);
    return {dev_mem[i], dev_mem[(i+1) & 63], dev_mem[(i+2) & 63], dev_mem[(i+3) & 63]};
  endfunction

  always_comb begin
    mem_rdata = 32'hDEADBEEF;
    if (mem_rd) mem_rdata = dev_word(mem_addr[5:0]);
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [64];
  logic [31:0] m_rdata;
  bit          m_last;

  function automatic bit exp_bad(input logic [31:0] a);
    return (a % 4 != 0) || (64'(a) + 64'd3 >= 64'd64);
  endfunction

  task automatic model_reset();
    m_rdata = 32'h0;
    m_last  = 1'b1;
  endtask

  task automatic model_apply(input bit p, input bit we, input logic [31:0] a,
                             input logic [31:0] d, output bit e, output logic [31:0] rd);
    e = exp_bad(a);
    if (!e) begin
      if (we) begin
        for (int k = 0; k < 4; k++) ref_mem[a + k] = d[31-8*k -: 8];
      end else begin
        m_rdata = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
      end
    end
    rd     = m_rdata;
    m_last = p;
  endtask

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit p, input bit v);
    if (p) req1 = v;
    else   req0 = v;
  endtask

  task automatic drive(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p) begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else   begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
  endtask

  // One complete access from the IDLE cycle in which the request is sampled:
  // SETUP, STROBE, DONE (ack), then back in IDLE.
  task automatic do_round(input bit w, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input bit e_err,
                          input logic [31:0] e_rdata, input bit drop_early);
    @(negedge CLK);
    chk("setup_busy", busy, 1);
    chk("setup_strobes", {mem_rd, mem_wr}, 0);
    chk("setup_acks", {ack0, ack1}, 0);
    chk("setup_addr", mem_addr, a);
    if (drop_early) set_req(w, 1'b0);
    @(negedge CLK);
    chk("strobe_rd", mem_rd, (!e_err && !we) ? 1 : 0);
    chk("strobe_wr", mem_wr, (!e_err && we) ? 1 : 0);
    chk("strobe_acks", {ack0, ack1}, 0);
    chk("strobe_addr", mem_addr, a);
    if (we && !e_err) chk("strobe_wdata", mem_wdata, d);
    @(negedge CLK);
    chk("done_ack_win", w ? ack1 : ack0, 1);
    chk("done_ack_other", w ? ack0 : ack1, 0);
    chk("done_err_win", w ? err1 : err0, e_err);
    chk("done_err_other", w ? err0 : err1, 0);
    chk("done_strobes", {mem_rd, mem_wr}, 0);
    chk("done_rdata", rdata, e_rdata);
    set_req(w, 1'b0);
    @(negedge CLK);
    chk("idle_busy", busy, 0);
    chk("idle_acks", {ack0, ack1, err0, err1}, 0);
    chk("idle_strobes", {mem_rd, mem_wr}, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          drop;       // release req during SETUP
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [31:0] gen_addr();
    case ($urandom % 4)
      0, 1:    return 32'(($urandom % 16) * 4);
      2:       return 32'($urandom % 64);
      default: return ($urandom % 2) ? 32'(60 + $urandom % 16) : (32'hFFFFFFF0 | 32'($urandom % 16));
    endcase
  endfunction

  initial begin
    bit          e, e2, w, both;
    logic [31:0] rd, rd2;
    int          pat, gi;
    bit          exp_p;

    tbl[0]  = '{0, 1, 32'h08, 32'h11223344, 0, 0, 32'h00000000};
    tbl[1]  = '{0, 0, 32'h08, 32'h0,        0, 0, 32'h11223344};
    tbl[2]  = '{1, 0, 32'h06, 32'h0,        0, 1, 32'h11223344};
    tbl[3]  = '{0, 1, 32'h3C, 32'hA5A55A5A, 0, 0, 32'h11223344};
    tbl[4]  = '{0, 1, 32'h40, 32'h0BADF00D, 0, 1, 32'h11223344};
    tbl[5]  = '{1, 0, 32'h3C, 32'h0,        0, 0, 32'hA5A55A5A};
    tbl[6]  = '{1, 0, 32'h10, 32'h0,        0, 0, 32'h10111213};
    tbl[7]  = '{0, 0, 32'h3D, 32'h0,        0, 1, 32'h10111213};
    tbl[8]  = '{1, 0, 32'hFFFFFFFC, 32'h0,  0, 1, 32'h10111213};
    tbl[9]  = '{1, 1, 32'h00, 32'hDEADBEEF, 0, 0, 32'h10111213};
    tbl[10] = '{0, 0, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF};
    tbl[11] = '{0, 0, 32'h40, 32'h0,        0, 1, 32'hDEADBEEF};
    tbl[12] = '{1, 0, 32'h3A, 32'h0,        0, 1, 32'hDEADBEEF};
    tbl[13] = '{1, 0, 32'h38, 32'h0,        1, 0, 32'h38393A3B};

    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = 8'(i);
      ref_mem[i] = 8'(i);
    end
    model_reset();
    Reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {ack0, ack1, err0, err1, mem_rd, mem_wr, busy}, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    Reset = 1'b0;
    @(negedge CLK);

    // ---- directed table ----
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      model_apply(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, e, rd);
      do_round(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
               tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].drop);
    end

    // ---- randomized transactions vs model ----
    for (int it = 0; it < 60; it++) begin
      pat = $urandom_range(1, 3);
      we0 = 1'($urandom % 2); addr0 = gen_addr(); wdata0 = $urandom;
      we1 = 1'($urandom % 2); addr1 = gen_addr(); wdata1 = $urandom;
      req0 = (pat != 2);
      req1 = (pat != 1);
      both = (pat == 3);
`ifdef DMEM_ARB_RR_EN
      w = both ? ~m_last : (pat == 2);
`else
      w = (pat == 2);
`endif
      model_apply(w, w ? we1 : we0, w ? addr1 : addr0, w ? wdata1 : wdata0, e, rd);
      do_round(w, w ? we1 : we0, w ? addr1 : addr0, w ? wdata1 : wdata0, e, rd, 0);
      if (both) begin
        model_apply(~w, w ? we0 : we1, w ? addr0 : addr1, w ? wdata0 : wdata1, e2, rd2);
        do_round(~w, w ? we0 : we1, w ? addr0 : addr1, w ? wdata0 : wdata1, e2, rd2, 0);
      end
    end

    // ---- continuous contention from reset: grants every 4 cycles ----
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    model_reset();
    we0 = 0; addr0 = 32'h10; we1 = 0; addr1 = 32'h14;
    req0 = 1'b1; req1 = 1'b1;
    gi = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k % 4 == 3) begin
`ifdef DMEM_ARB_RR_EN
        exp_p = 1'(gi % 2);
`else
        exp_p = 1'b0;
`endif
        chk("contend_ack0", ack0, exp_p ? 0 : 1);
        chk("contend_ack1", ack1, exp_p ? 1 : 0);
        model_apply(exp_p, 1'b0, exp_p ? addr1 : addr0, 32'h0, e, rd);
        chk("contend_rdata", rdata, rd);
        gi++;
      end else begin
        chk("contend_noack", {ack0, ack1}, 0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;

    // ---- reset during STROBE of a read, then re-request ----
    drive(0, 1'b0, 32'h3C, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_mid_strobe_rd", mem_rd, 1);
    Reset = 1'b1;
    @(negedge CLK);
    chk("rst_mid_outputs", {ack0, ack1, err0, err1, mem_rd, mem_wr, busy}, 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_addr", mem_addr, 0);
    Reset = 1'b0;
    model_reset();
    model_apply(0, 1'b0, 32'h3C, 32'h0, e, rd);
    do_round(0, 1'b0, 32'h3C, 32'h0, e, rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
